// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the registered multi-cycle ALU.
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_SLT = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_MUL = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: consumes MUL_STEP multiplier bits per cycle.
// o_done is high during the final step; o_prod is then the complete 2*WIDTH product.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned MUL_STEP = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_prod
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / MUL_STEP - 1);

   logic                 r_busy;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   w_pp;

   always_comb begin
      w_pp = '0;
      for (int unsigned j = 0; j < MUL_STEP; j++) begin
         if (r_mplier[j]) w_pp = w_pp + (r_mcand << j);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= CNT_LAST;
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= r_acc + w_pp;
         r_mcand  <= r_mcand << MUL_STEP;
         r_mplier <= r_mplier >> MUL_STEP;
         r_cnt    <= r_cnt - CNT_W'(1);
         if (r_cnt == '0) r_busy <= 1'b0;
      end
   end

   assign o_done = r_busy && (r_cnt == '0);
   assign o_prod = r_acc + w_pp;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready on both sides; single-cycle ops complete in one
// cycle, MUL is delegated to the iterative multiplier while the FSM sits in BUSY.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned MUL_STEP = 1
) (
   input  logic              Clock,
   input  logic              ResetN,
   input  logic              InValid,
   output logic              InReady,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic              BNegate,
   input  logic [2:0]        ALUCtrl,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [WIDTH-1:0]  REZ,
   output logic              Zero,
   output logic              Overflow,
   output logic              CarryOut
);

   localparam int unsigned SH_W = $clog2(WIDTH);

   if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("alu_multicycle: WIDTH must be a power of 2 and >= 4");
   end
   if (((MUL_STEP != 1) && (MUL_STEP != 2) && (MUL_STEP != 4)) || ((WIDTH % MUL_STEP) != 0)) begin : g_bad_step
      $error("alu_multicycle: MUL_STEP must be 1, 2 or 4 and divide WIDTH");
   end

   state_t                r_state, w_state_next;
   logic                  r_out_valid, r_zero, r_ovf, r_carry;
   logic [WIDTH-1:0]      r_rez;

   logic                  w_accept, w_mul_start, w_load_alu, w_load_mul, w_mul_done;
   logic [2*WIDTH-1:0]    w_mul_prod;
   logic [WIDTH-1:0]      w_b_eff, w_sum, w_sub, w_res;
   logic                  w_sum_c, w_add_ovf, w_sub_ovf, w_slt, w_res_c, w_res_o;
   logic [SH_W-1:0]       w_shamt;
   logic [WIDTH:0]        w_sll_ext, w_srl_ext;
   logic signed [WIDTH:0] w_sra_ext;

   assign w_b_eff             = BNegate ? ~B : B;
   assign {w_sum_c, w_sum}    = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, BNegate};
   assign w_add_ovf           = (A[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
   assign w_sub               = A - B;
   assign w_sub_ovf           = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
   assign w_slt               = w_sub[WIDTH-1] ^ w_sub_ovf;

   // One guard bit catches the last bit shifted out; it stays 0 for amount 0.
   assign w_shamt   = B[SH_W-1:0];
   assign w_sll_ext = {1'b0, A} << w_shamt;
   assign w_srl_ext = {A, 1'b0} >> w_shamt;
   assign w_sra_ext = $signed({A, 1'b0}) >>> w_shamt;

   always_comb begin
      w_res   = '0;
      w_res_c = 1'b0;
      w_res_o = 1'b0;
      case (ALUCtrl)
         ALU_AND: w_res = A & B;
         ALU_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
         ALU_OR:  w_res = A | B;
         ALU_XOR: w_res = A ^ B;
         ALU_ADD: begin
            w_res   = w_sum;
            w_res_c = w_sum_c;
            w_res_o = w_add_ovf;
         end
         ALU_SLL: begin
            w_res   = w_sll_ext[WIDTH-1:0];
            w_res_c = w_sll_ext[WIDTH];
         end
         ALU_SRL: begin
            if (BNegate) begin
               w_res   = w_sra_ext[WIDTH:1];
               w_res_c = w_sra_ext[0];
            end else begin
               w_res   = w_srl_ext[WIDTH:1];
               w_res_c = w_srl_ext[0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_mul_start) w_state_next = ST_BUSY;
         ST_BUSY: if (w_mul_done)  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      InReady     = ResetN && (r_state == ST_IDLE) && (!r_out_valid || OutReady);
      w_accept    = InValid && InReady;
      w_mul_start = w_accept && (ALUCtrl == ALU_MUL);
      w_load_alu  = w_accept && (ALUCtrl != ALU_MUL);
      w_load_mul  = (r_state == ST_BUSY) && w_mul_done;
   end

   alu_mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .i_clk   (Clock),
      .i_rst_n (ResetN),
      .i_start (w_mul_start),
      .i_a     (A),
      .i_b     (B),
      .o_done  (w_mul_done),
      .o_prod  (w_mul_prod)
   );

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         r_out_valid <= 1'b0;
         r_rez       <= '0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_carry     <= 1'b0;
      end else if (w_load_alu) begin
         r_out_valid <= 1'b1;
         r_rez       <= w_res;
         r_zero      <= (w_res == '0);
         r_ovf       <= w_res_o;
         r_carry     <= w_res_c;
      end else if (w_load_mul) begin
         r_out_valid <= 1'b1;
         r_rez       <= w_mul_prod[WIDTH-1:0];
         r_zero      <= (w_mul_prod[WIDTH-1:0] == '0);
         r_ovf       <= 1'b0;
         r_carry     <= |w_mul_prod[2*WIDTH-1:WIDTH];
      end else if (w_accept || (r_out_valid && OutReady)) begin
         r_out_valid <= 1'b0;
      end
   end

   assign OutValid = r_out_valid;
   assign REZ      = r_rez;
   assign Zero     = r_zero;
   assign Overflow = r_ovf;
   assign CarryOut = r_carry;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench: main 16-bit/step-1 ALU plus 16-bit/step-4 and 8-bit variants.
module tb_alu_multicycle;
   import alu_pkg::*;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;
   logic ResetN;

   logic iv, ir, bn, ov, ordy, z, o, c;
   logic [2:0] ctl;
   logic [15:0] a, b, rez;
   logic iv4, ir4, bn4, ov4, ordy4, z4, o4, c4;
   logic [2:0] ctl4;
   logic [15:0] a4, b4, rez4;
   logic iv8, ir8, bn8, ov8, ordy8, z8, o8, c8;
   logic [2:0] ctl8;
   logic [7:0] a8, b8, rez8;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc;
   logic seen;

   alu_multicycle #(.WIDTH(16), .MUL_STEP(1)) dut (
      .Clock(Clock), .ResetN(ResetN), .InValid(iv), .InReady(ir), .A(a), .B(b),
      .BNegate(bn), .ALUCtrl(ctl), .OutValid(ov), .OutReady(ordy), .REZ(rez),
      .Zero(z), .Overflow(o), .CarryOut(c));

   alu_multicycle #(.WIDTH(16), .MUL_STEP(4)) dut4 (
      .Clock(Clock), .ResetN(ResetN), .InValid(iv4), .InReady(ir4), .A(a4), .B(b4),
      .BNegate(bn4), .ALUCtrl(ctl4), .OutValid(ov4), .OutReady(ordy4), .REZ(rez4),
      .Zero(z4), .Overflow(o4), .CarryOut(c4));

   alu_multicycle #(.WIDTH(8), .MUL_STEP(1)) dut8 (
      .Clock(Clock), .ResetN(ResetN), .InValid(iv8), .InReady(ir8), .A(a8), .B(b8),
      .BNegate(bn8), .ALUCtrl(ctl8), .OutValid(ov8), .OutReady(ordy8), .REZ(rez8),
      .Zero(z8), .Overflow(o8), .CarryOut(c8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op16(input logic [2:0] c_, input logic bn_, input logic [15:0] a_, input logic [15:0] b_);
      ctl = c_; bn = bn_; a = a_; b = b_; iv = 1'b1;
      @(negedge Clock);
      iv = 1'b0;
   endtask

   task automatic op4(input logic [2:0] c_, input logic bn_, input logic [15:0] a_, input logic [15:0] b_);
      ctl4 = c_; bn4 = bn_; a4 = a_; b4 = b_; iv4 = 1'b1;
      @(negedge Clock);
      iv4 = 1'b0;
   endtask

   task automatic op8(input logic [2:0] c_, input logic bn_, input logic [7:0] a_, input logic [7:0] b_);
      ctl8 = c_; bn8 = bn_; a8 = a_; b8 = b_; iv8 = 1'b1;
      @(negedge Clock);
      iv8 = 1'b0;
   endtask

   // Counts cycles from the accept until OutValid rises, checking InReady stays low meanwhile.
   task automatic wait_out(input int sel, output int cyc_o);
      logic v_, r_;
      cyc_o = 0;
      for (int k = 0; k < 40; k++) begin
         case (sel)
            0:       begin v_ = ov;  r_ = ir;  end
            1:       begin v_ = ov4; r_ = ir4; end
            default: begin v_ = ov8; r_ = ir8; end
         endcase
         if (v_) break;
         chk($sformatf("busy_inready_%0d", sel), {31'd0, r_}, 32'd0);
         @(negedge Clock);
         cyc_o++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      ResetN = 1'b0;
      iv = 0; bn = 0; ctl = '0; a = '0; b = '0; ordy = 1'b1;
      iv4 = 0; bn4 = 0; ctl4 = '0; a4 = '0; b4 = '0; ordy4 = 1'b1;
      iv8 = 0; bn8 = 0; ctl8 = '0; a8 = '0; b8 = '0; ordy8 = 1'b1;
      #2;
      chk("rst_outvalid", ov, 0);
      chk("rst_rez", rez, 0);
      chk("rst_zero", z, 0);
      chk("rst_ovf", o, 0);
      chk("rst_carry", c, 0);
      chk("rst_inready", ir, 0);
      chk("rst_inready8", ir8, 0);
      @(negedge Clock);
      ResetN = 1'b1;
      #1;
      chk("post_rst_inready", ir, 1);

      op16(ALU_ADD, 0, 16'd10, 16'd20);
      chk("add_valid", ov, 1);
      chk("add_rez", rez, 30);
      chk("add_zero", z, 0);
      chk("add_carry", c, 0);
      op16(ALU_ADD, 1, 16'd10, 16'd10);
      chk("sub_rez", rez, 0);
      chk("sub_zero", z, 1);
      chk("sub_carry", c, 1);
      chk("sub_ovf", o, 0);

      op16(ALU_ADD, 0, 16'h7FFF, 16'h0001);
      chk("ovf_rez", rez, 16'h8000);
      chk("ovf_ovf", o, 1);
      chk("ovf_carry", c, 0);
      op16(ALU_ADD, 0, 16'hFFFF, 16'h0001);
      chk("wrap_rez", rez, 0);
      chk("wrap_zero", z, 1);
      chk("wrap_carry", c, 1);
      chk("wrap_ovf", o, 0);

      op16(ALU_SLT, 0, 16'd1, 16'd3);
      chk("slt_1_3", rez, 1);
      op16(ALU_SLT, 1, 16'd5, 16'd3);
      chk("slt_5_3", rez, 0);
      op16(ALU_SLT, 0, 16'hFFFF, 16'd1);
      chk("slt_m1_1", rez, 1);
      op16(ALU_SRL, 1, 16'h8000, 16'd15);
      chk("sra_rez", rez, 16'hFFFF);
      chk("sra_carry", c, 0);
      op16(ALU_SLL, 0, 16'h8001, 16'd1);
      chk("sll_rez", rez, 16'h0002);
      chk("sll_carry", c, 1);
      op16(ALU_SRL, 0, 16'h0003, 16'd1);
      chk("srl_rez", rez, 16'h0001);
      chk("srl_carry", c, 1);
      op16(ALU_SLL, 0, 16'h8001, 16'd0);
      chk("sll0_carry", c, 0);
      op16(ALU_OR, 0, 16'h0F00, 16'h00F0);
      chk("or_rez", rez, 16'h0FF0);

      op16(ALU_MUL, 0, 16'd300, 16'd300);
      chk("mul_busy_valid", ov, 0);
      wait_out(0, cyc);
      chk("mul_latency", cyc, 16);
      chk("mul_rez", rez, 16'h5F90);
      chk("mul_carry", c, 1);
      chk("mul_ovf", o, 0);

      op16(ALU_XOR, 0, 16'h00F0, 16'h0FF0);
      ordy = 1'b0;
      ctl = ALU_AND; bn = 0; a = 16'd6; b = 16'd3; iv = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clock);
         chk("bp_valid", ov, 1);
         chk("bp_rez", rez, 16'h0F00);
         chk("bp_zero", z, 0);
         chk("bp_inready", ir, 0);
      end
      ordy = 1'b1;
      #1;
      chk("bp_release_inready", ir, 1);
      @(negedge Clock);
      iv = 1'b0;
      chk("nobubble_valid", ov, 1);
      chk("nobubble_rez", rez, 2);
      @(negedge Clock);
      chk("drain_valid", ov, 0);

      op16(ALU_ADD, 1, 16'd10, 16'd5);
      chk("presub_rez", rez, 5);
      op16(ALU_MUL, 0, 16'd300, 16'd300);
      repeat (6) @(negedge Clock);
      ResetN = 1'b0;
      #1;
      chk("midrst_valid", ov, 0);
      chk("midrst_rez", rez, 0);
      chk("midrst_zero", z, 0);
      chk("midrst_ovf", o, 0);
      chk("midrst_carry", c, 0);
      chk("midrst_inready", ir, 0);
      @(negedge Clock);
      ResetN = 1'b1;
      #1;
      chk("rel_inready", ir, 1);
      seen = 1'b0;
      repeat (20) begin
         @(negedge Clock);
         if (ov) seen = 1'b1;
      end
      chk("rel_no_valid", seen, 0);
      op16(ALU_MUL, 0, 16'd3, 16'd5);
      wait_out(0, cyc);
      chk("mul2_latency", cyc, 16);
      chk("mul2_rez", rez, 15);
      chk("mul2_carry", c, 0);

      op4(ALU_MUL, 0, 16'd300, 16'd300);
      wait_out(1, cyc);
      chk("mul4_latency", cyc, 4);
      chk("mul4_rez", rez4, 16'h5F90);
      chk("mul4_carry", c4, 1);

      op8(ALU_ADD, 0, 8'd10, 8'd20);
      chk("w8_add_valid", ov8, 1);
      chk("w8_add_rez", rez8, 30);
      op8(ALU_ADD, 1, 8'd10, 8'd10);
      chk("w8_sub_rez", rez8, 0);
      chk("w8_sub_zero", z8, 1);
      chk("w8_sub_carry", c8, 1);
      op8(ALU_ADD, 0, 8'h7F, 8'h01);
      chk("w8_ovf_rez", rez8, 8'h80);
      chk("w8_ovf_ovf", o8, 1);
      chk("w8_ovf_carry", c8, 0);
      op8(ALU_ADD, 0, 8'hFF, 8'h01);
      chk("w8_wrap_rez", rez8, 0);
      chk("w8_wrap_zero", z8, 1);
      chk("w8_wrap_carry", c8, 1);
      chk("w8_wrap_ovf", o8, 0);
      op8(ALU_SLT, 0, 8'd1, 8'd3);
      chk("w8_slt_1_3", rez8, 1);
      op8(ALU_SLT, 0, 8'd5, 8'd3);
      chk("w8_slt_5_3", rez8, 0);
      op8(ALU_SLT, 0, 8'hFF, 8'd1);
      chk("w8_slt_m1_1", rez8, 1);
      op8(ALU_SRL, 1, 8'h80, 8'd7);
      chk("w8_sra_rez", rez8, 8'hFF);
      chk("w8_sra_carry", c8, 0);
      op8(ALU_MUL, 0, 8'd20, 8'd20);
      wait_out(2, cyc);
      chk("w8_mul_latency", cyc, 8);
      chk("w8_mul_rez", rez8, 8'h90);
      chk("w8_mul_carry", c8, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
